// File: rtl/subr_pkg.sv
// subr_pkg: shared widths, types and helpers for the subr_unit subtractor.
// Holds the default operand width, operand/result/stat types, sat increment.
package subr_pkg;

  localparam int SUBR_WIDTH  = 3;
  localparam int SUBR_RES_W  = SUBR_WIDTH + 1;
  localparam int SUBR_STAT_W = 16;

  typedef logic [SUBR_WIDTH-1:0]  subr_opnd_t;
  typedef logic [SUBR_RES_W-1:0]  subr_res_t;
  typedef logic [SUBR_STAT_W-1:0] subr_stat_t;

  localparam subr_stat_t SUBR_STAT_MAX = '1;

  function automatic subr_stat_t sat_inc(
    input subr_stat_t v
  );
    return (v == SUBR_STAT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/subr_fs.sv
// subr_fs: 1-bit full subtractor cell (a - b - bin).
// Ports: a, b, bin in; d difference bit, bout borrow-out.
module subr_fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign d     = w_axb ^ bin;
  // Borrow when b exceeds a, or when a==b and a borrow ripples in.
  assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/subr_unit.sv
// subr_unit: registered c1 - d1 - borrow, WIDTH+1 bit two's-complement result.
// Ports: clk, rst (sync, active-high), c1/d1 operands, i1_input borrow-in,
//   in_valid, chain (use stored borrow); outputs sum3, o1_output (borrow),
//   out_valid, zero. Macro SUBR_STATS_EN adds op_count / borrow_count.
module subr_unit
  import subr_pkg::*;
#(
  parameter int WIDTH = SUBR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] c1,
  input  logic [WIDTH-1:0] d1,
  input  logic             i1_input,
  input  logic             in_valid,
  input  logic             chain,
  output logic [WIDTH:0]   sum3,
  output logic             o1_output,
  output logic             out_valid,
  output logic             zero
`ifdef SUBR_STATS_EN
  ,
  output logic [SUBR_STAT_W-1:0] op_count,
  output logic [SUBR_STAT_W-1:0] borrow_count
`endif
);

  logic             w_bin;
  logic [WIDTH:0]   w_bw;
  logic [WIDTH-1:0] w_d;
  logic [WIDTH:0]   w_diff;
  logic             w_bout;

  logic [WIDTH:0]   r_sum;
  logic             r_bout;
  logic             r_valid;
  logic             r_zero;
  logic             r_borrow_q;

  // Chain mode takes the borrow left by the previous accepted op,
  // straight from the register, so back-to-back chaining has no bubble.
  assign w_bin   = chain ? r_borrow_q : i1_input;
  assign w_bw[0] = w_bin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fs
    subr_fs u_fs (
      .a    (c1[gi]),
      .b    (d1[gi]),
      .bin  (w_bw[gi]),
      .d    (w_d[gi]),
      .bout (w_bw[gi+1])
    );
  end

  // Zero-extended operands: the top result bit is exactly the borrow-out.
  assign w_bout = w_bw[WIDTH];
  assign w_diff = {w_bout, w_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum      <= '0;
      r_bout     <= 1'b0;
      r_valid    <= 1'b0;
      r_zero     <= 1'b1;
      r_borrow_q <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum      <= w_diff;
        r_bout     <= w_bout;
        r_zero     <= (w_diff == '0);
        r_borrow_q <= w_bout;
      end
    end
  end

  assign sum3      = r_sum;
  assign o1_output = r_bout;
  assign out_valid = r_valid;
  assign zero      = r_zero;

`ifdef SUBR_STATS_EN
  subr_stat_t r_op_cnt;
  subr_stat_t r_brw_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_cnt  <= '0;
      r_brw_cnt <= '0;
    end else if (in_valid) begin
      r_op_cnt <= sat_inc(r_op_cnt);
      if (w_bout) begin
        r_brw_cnt <= sat_inc(r_brw_cnt);
      end
    end
  end

  assign op_count     = r_op_cnt;
  assign borrow_count = r_brw_cnt;
`endif

endmodule

// File: tb/tb_subr_unit.sv
// tb_subr_unit: table vectors, chain sequences and a shuffled sweep of all
// operand/borrow combinations checked against an arithmetic model.
module tb_subr_unit;
  import subr_pkg::*;

  localparam int W = SUBR_WIDTH;

  logic         clk;
  logic         rst;
  logic [W-1:0] c1;
  logic [W-1:0] d1;
  logic         i1_input;
  logic         in_valid;
  logic         chain;
  logic [W:0]   sum3;
  logic         o1_output;
  logic         out_valid;
  logic         zero;
`ifdef SUBR_STATS_EN
  logic [SUBR_STAT_W-1:0] op_count;
  logic [SUBR_STAT_W-1:0] borrow_count;
`endif

  subr_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .c1        (c1),
    .d1        (d1),
    .i1_input  (i1_input),
    .in_valid  (in_valid),
    .chain     (chain),
    .sum3      (sum3),
    .o1_output (o1_output),
    .out_valid (out_valid),
    .zero      (zero)
`ifdef SUBR_STATS_EN
    ,
    .op_count     (op_count),
    .borrow_count (borrow_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state, derived from plain integer arithmetic.
  int m_borrow;
  int m_sum;
  int m_bo;
  int m_zero;
  int m_ops;
  int m_brw;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic m_reset();
    m_borrow = 0;
    m_sum = 0;
    m_bo = 0;
    m_zero = 1;
    m_ops = 0;
    m_brw = 0;
  endtask

  task automatic m_op(input int c, input int d, input int bi, input int ch);
    int b;
    int diff;
    b = ch ? m_borrow : bi;
    diff = c - d - b;
    m_sum = diff & ((1 << (W + 1)) - 1);
    m_bo = (diff < 0) ? 1 : 0;
    m_zero = (diff == 0) ? 1 : 0;
    m_borrow = m_bo;
    m_ops++;
    if (m_bo != 0) m_brw++;
  endtask

  task automatic chk_model(input string tag, input int vexp);
    chk({tag, ".sum3"}, int'(sum3), m_sum);
    chk({tag, ".borrow"}, int'(o1_output), m_bo);
    chk({tag, ".zero"}, int'(zero), m_zero);
    chk({tag, ".valid"}, int'(out_valid), vexp);
  endtask

  // Inputs are driven on the falling edge, outputs read one edge later.
  task automatic do_op(input int c, input int d, input int bi, input int ch);
    rst = 1'b0;
    in_valid = 1'b1;
    c1 = W'(c);
    d1 = W'(d);
    i1_input = 1'(bi);
    chain = 1'(ch);
    m_op(c, d, bi, ch);
    @(negedge clk);
  endtask

  task automatic do_idle();
    rst = 1'b0;
    in_valid = 1'b0;
    c1 = W'($urandom);
    d1 = W'($urandom);
    i1_input = 1'($urandom);
    chain = 1'($urandom);
    @(negedge clk);
  endtask

  task automatic do_reset(input int with_op);
    rst = 1'b1;
    in_valid = 1'(with_op);
    c1 = 1;
    d1 = 3;
    i1_input = 1'b1;
    chain = 1'b0;
    m_reset();
    @(negedge clk);
  endtask

  typedef struct {
    int c;
    int d;
    int bi;
    int es;
    int eb;
    int ez;
  } vec_t;

  vec_t tbl[6];
  int order[128];

  initial begin
    tbl[0] = '{c: 1, d: 1, bi: 1, es: 15, eb: 1, ez: 0};
    tbl[1] = '{c: 7, d: 0, bi: 0, es: 7,  eb: 0, ez: 0};
    tbl[2] = '{c: 0, d: 7, bi: 1, es: 8,  eb: 1, ez: 0};
    tbl[3] = '{c: 3, d: 3, bi: 0, es: 0,  eb: 0, ez: 1};
    tbl[4] = '{c: 5, d: 2, bi: 1, es: 2,  eb: 0, ez: 0};
    tbl[5] = '{c: 0, d: 0, bi: 0, es: 0,  eb: 0, ez: 1};

    rst = 1'b1;
    in_valid = 1'b0;
    c1 = '0;
    d1 = '0;
    i1_input = 1'b0;
    chain = 1'b0;
    m_reset();
    @(negedge clk);

    // Reset wins over a simultaneous valid op.
    do_reset(1);
    chk("rst.sum3", int'(sum3), 0);
    chk("rst.borrow", int'(o1_output), 0);
    chk("rst.valid", int'(out_valid), 0);
    chk("rst.zero", int'(zero), 1);
`ifdef SUBR_STATS_EN
    chk("rst.op_count", int'(op_count), 0);
    chk("rst.borrow_count", int'(borrow_count), 0);
`endif

    // Stored borrow was cleared: chain yields 2-1-0.
    do_op(2, 1, 1, 1);
    chk("rst_chain.sum3", int'(sum3), 1);
    chk("rst_chain.valid", int'(out_valid), 1);

    for (int k = 0; k < 6; k++) begin
      do_op(tbl[k].c, tbl[k].d, tbl[k].bi, 0);
      chk($sformatf("tbl%0d.sum3", k), int'(sum3), tbl[k].es);
      chk($sformatf("tbl%0d.borrow", k), int'(o1_output), tbl[k].eb);
      chk($sformatf("tbl%0d.zero", k), int'(zero), tbl[k].ez);
      chk($sformatf("tbl%0d.valid", k), int'(out_valid), 1);
    end

    // Back-to-back chain: 0-1 borrows, then 5-2-1 = 2.
    do_reset(0);
    do_op(0, 1, 0, 0);
    chk("ch1.sum3", int'(sum3), 15);
    chk("ch1.borrow", int'(o1_output), 1);
    do_op(5, 2, 0, 1);
    chk("ch2.sum3", int'(sum3), 2);
    chk("ch2.borrow", int'(o1_output), 0);
    chk("ch2.valid", int'(out_valid), 1);

    // Borrow held across idle cycles, chain with in_valid=0 is inert.
    do_op(0, 1, 0, 0);
    do_idle();
    chk("hold.valid", int'(out_valid), 0);
    chk("hold.sum3", int'(sum3), 15);
    do_idle();
    do_op(4, 1, 0, 1);
    chk("hold_ch.sum3", int'(sum3), 2);
    chk("hold_ch.valid", int'(out_valid), 1);
    do_idle();
    chk("gap.valid", int'(out_valid), 0);

    // Five ops, three borrowing.
    do_reset(0);
    do_op(0, 1, 0, 0);
    do_op(5, 2, 0, 0);
    do_op(0, 7, 1, 0);
    do_op(7, 0, 0, 0);
    do_op(3, 3, 1, 0);
    chk_model("five", 1);
`ifdef SUBR_STATS_EN
    chk("five.op_count", int'(op_count), 5);
    chk("five.borrow_count", int'(borrow_count), 3);
`endif

    // Shuffled sweep of every {c1, d1, i1_input} with random chain/gaps.
    for (int k = 0; k < 128; k++) order[k] = k;
    for (int k = 127; k > 0; k--) begin
      int j;
      int t;
      j = int'($urandom_range(k, 0));
      t = order[k];
      order[k] = order[j];
      order[j] = t;
    end
    for (int k = 0; k < 128; k++) begin
      int v;
      v = order[k];
      if ($urandom_range(3, 0) == 0) begin
        do_idle();
        chk_model($sformatf("gap%0d", k), 0);
      end
      do_op((v >> 4) & 7, (v >> 1) & 7, v & 1, int'($urandom_range(1, 0)));
      chk_model($sformatf("sw%0d", k), 1);
    end

`ifdef SUBR_STATS_EN
    chk("sw.op_count", int'(op_count), m_ops);
    chk("sw.borrow_count", int'(borrow_count), m_brw);
`endif

    do_reset(1);
    chk_model("final_rst", 0);
`ifdef SUBR_STATS_EN
    chk("final_rst.op_count", int'(op_count), 0);
    chk("final_rst.borrow_count", int'(borrow_count), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
